// File: rtl/mem_sram_responder_if.sv
// Mem-bus request/response types and the valid/ready interface that carries
// them between a requester (master) and the SRAM responder (slave).
package mem_pkg;

    localparam logic [1:0] MEM_READ  = 2'd0;
    localparam logic [1:0] MEM_WRITE = 2'd1;

    typedef struct packed {
        logic [1:0]  req_type;
        logic [31:0] req_addr;
        logic [31:0] req_data;
        logic [3:0]  req_mask;
    } mem_req_t;

    typedef struct packed {
        logic [1:0]  resp_type;
        logic [31:0] resp_data;
    } mem_resp_t;

endpackage

interface mem_sram_responder_if;
    import mem_pkg::*;

    logic      req_valid;
    logic      req_ready;
    mem_req_t  req;
    logic      resp_valid;
    logic      resp_ready;
    mem_resp_t resp;

    modport master (
        output req_valid,
        output req,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp
    );

    modport slave (
        input  req_valid,
        input  req,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp
    );

endinterface

// File: rtl/mem_sram_responder.sv
// Mem-bus target: executes one request at a time against a byte-maskable
// word SRAM and returns in-order responses on a valid/ready handshake.
// Optional feature macro MEM_SRAM_RESP_WR_ACK_EN: when defined, writes are
// acknowledged with a MEM_WRITE response; otherwise writes are posted.
module mem_sram_responder
    import mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_sram_responder_if.slave  bus
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Counter preload so that RESP is entered RD_LAT-1 edges after accept,
    // making resp_valid visible in the RD_LAT-th cycle after the accept edge.
    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    logic [31:0]       mem [MEM_DEPTH];

    logic [1:0]        state_r;
    logic [1:0]        state_s;
    logic [2:0]        lat_cnt_r;
    logic [2:0]        lat_cnt_s;
    logic [ADDR_W-1:0] rd_idx_r;
    logic [1:0]        rd_type_r;
    logic              resp_valid_r;
    mem_resp_t         resp_r;

    logic              accept_s;
    logic              is_write_s;
    logic [ADDR_W-1:0] req_idx_s;
    logic [ADDR_W-1:0] rd_sel_idx_s;
    logic [1:0]        rd_sel_type_s;
    logic [31:0]       rd_word_s;
    logic              load_rd_s;
    logic              load_wr_s;
    logic              clear_s;
    logic              unused_addr_s;

    // Address bits outside the word index are deliberately ignored.
    assign unused_addr_s = ^{bus.req.req_addr[31:ADDR_W+2], bus.req.req_addr[1:0]};

    assign bus.req_ready  = (state_r == ST_IDLE) && !rst;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp       = resp_r;

    assign accept_s   = bus.req_valid && bus.req_ready;
    assign is_write_s = (bus.req.req_type == MEM_WRITE);
    assign req_idx_s  = bus.req.req_addr[ADDR_W+1:2];

    // With RD_LAT==1 the word is captured straight from the live request;
    // longer latencies use the index/type latched at the accept edge.
    assign rd_sel_idx_s  = (state_r == ST_IDLE) ? req_idx_s        : rd_idx_r;
    assign rd_sel_type_s = (state_r == ST_IDLE) ? bus.req.req_type : rd_type_r;
    assign rd_word_s     = mem[rd_sel_idx_s];

    // Next-state, latency counter and response-load decisions.
    always_comb begin
        state_s   = state_r;
        lat_cnt_s = lat_cnt_r;
        load_rd_s = 1'b0;
        load_wr_s = 1'b0;
        clear_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_write_s) begin
`ifdef MEM_SRAM_RESP_WR_ACK_EN
                        state_s   = ST_RESP;
                        load_wr_s = 1'b1;
`else
                        state_s   = ST_IDLE;
`endif
                    end else if (RD_LAT == 1) begin
                        state_s   = ST_RESP;
                        load_rd_s = 1'b1;
                    end else begin
                        state_s   = ST_ACCESS;
                        lat_cnt_s = LAT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (lat_cnt_r <= 3'd1) begin
                    state_s   = ST_RESP;
                    lat_cnt_s = 3'd0;
                    load_rd_s = 1'b1;
                end else begin
                    lat_cnt_s = lat_cnt_r - 3'd1;
                end
            end
            ST_RESP: begin
                if (resp_valid_r && bus.resp_ready) begin
                    state_s = ST_IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                lat_cnt_s = 3'd0;
            end
        endcase
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            lat_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_s;
            lat_cnt_r <= lat_cnt_s;
        end
    end

    // Latch read index and type at the accept edge for multi-cycle reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx_r  <= '0;
            rd_type_r <= 2'd0;
        end else if (accept_s) begin
            rd_idx_r  <= req_idx_s;
            rd_type_r <= bus.req.req_type;
        end
    end

    // Response register: loaded when entering RESP, held until handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_r <= 1'b0;
            resp_r       <= '0;
        end else if (load_rd_s) begin
            resp_valid_r     <= 1'b1;
            resp_r.resp_type <= rd_sel_type_s;
            resp_r.resp_data <= rd_word_s;
        end else if (load_wr_s) begin
            resp_valid_r     <= 1'b1;
            resp_r.resp_type <= MEM_WRITE;
            resp_r.resp_data <= 32'h0000_0000;
        end else if (clear_s) begin
            resp_valid_r <= 1'b0;
        end
    end

    // Byte-masked SRAM write on the accept edge; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept_s && is_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req.req_mask[i]) begin
                    mem[req_idx_s][8*i +: 8] <= bus.req.req_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed self-checking bench for mem_sram_responder (RD_LAT=3).
module tb_mem_sram_responder;
    import mem_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int RD_LAT    = 3;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    mem_sram_responder_if ifc ();

    mem_sram_responder #(.MEM_DEPTH(MEM_DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request at a negedge, wait (bounded) for ready, return at the
    // negedge right after the accept edge with req_valid dropped.
    task automatic issue(input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        ifc.req.req_type = t;
        ifc.req.req_addr = a;
        ifc.req.req_data = d;
        ifc.req.req_mask = m;
        ifc.req_valid    = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (ifc.req_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        issue(MEM_WRITE, a, d, m);
        for (int n = 0; n < 20; n++) begin
            if (!ifc.resp_valid) break;
            @(negedge clk);
        end
    endtask

    // lat = index of the first post-accept cycle with resp_valid (0 = timeout).
    task automatic bus_read(input logic [1:0] t, input logic [31:0] a,
                            output logic [31:0] d, output logic [1:0] rt, output int lat);
        d   = 32'h0;
        rt  = 2'd0;
        lat = 0;
        issue(t, a, 32'h0, 4'h0);
        for (int n = 1; n <= 20; n++) begin
            if (ifc.resp_valid) begin
                lat = n;
                d   = ifc.resp.resp_data;
                rt  = ifc.resp.resp_type;
                break;
            end
            @(negedge clk);
        end
        if (lat != 0 && ifc.resp_ready) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++;
        if (ifc.req_ready !== 1'b0) $display("FAIL reset_req_ready got %b want 0", ifc.req_ready);
        else pass_cnt++;
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        total_cnt++;
        if (ifc.resp !== 34'h0) $display("FAIL reset_resp got %h want 0", ifc.resp);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ifc.req_ready !== 1'b1) $display("FAIL post_reset_ready got %b want 1", ifc.req_ready);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        bus_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        bus_read(MEM_READ, 32'h10, d, rt, lat);
        total_cnt++;
        if (d !== 32'hDEAD_BEEF) $display("FAIL t1_data got %h want deadbeef", d);
        else pass_cnt++;
        total_cnt++;
        if (lat != RD_LAT) $display("FAIL t1_latency got %0d want %0d", lat, RD_LAT);
        else pass_cnt++;
        total_cnt++;
        if (rt !== MEM_READ) $display("FAIL t1_type got %0d want %0d", rt, MEM_READ);
        else pass_cnt++;
    endtask

    task automatic test_partial_write();
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        bus_write(32'h10, 32'h1234_5678, 4'b0011);
        bus_read(MEM_READ, 32'h10, d, rt, lat);
        total_cnt++;
        if (d !== 32'hDEAD_5678) $display("FAIL t2_masked_data got %h want dead5678", d);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        bus_write(32'h40, 32'h5555_AAAA, 4'hF);
        ifc.resp_ready = 1'b0;
        issue(MEM_READ, 32'h10, 32'h0, 4'h0);
        for (int n = 0; n < 20; n++) begin
            if (ifc.resp_valid) break;
            @(negedge clk);
        end
        // A competing write is presented and must not be accepted.
        ifc.req.req_type = MEM_WRITE;
        ifc.req.req_addr = 32'h40;
        ifc.req.req_data = 32'h0BAD_0BAD;
        ifc.req.req_mask = 4'hF;
        ifc.req_valid    = 1'b1;
        for (int c = 0; c < 10; c++) begin
            total_cnt++;
            if (ifc.resp_valid !== 1'b1) $display("FAIL t3_valid_held cyc %0d got %b want 1", c, ifc.resp_valid);
            else pass_cnt++;
            total_cnt++;
            if (ifc.resp.resp_data !== 32'hDEAD_5678) $display("FAIL t3_data_stable cyc %0d got %h want dead5678", c, ifc.resp.resp_data);
            else pass_cnt++;
            total_cnt++;
            if (ifc.req_ready !== 1'b0) $display("FAIL t3_ready_low cyc %0d got %b want 0", c, ifc.req_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        ifc.req_valid  = 1'b0;
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL t3_valid_after_hs got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL t3_single_resp got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        bus_read(MEM_READ, 32'h40, d, rt, lat);
        total_cnt++;
        if (d !== 32'h5555_AAAA) $display("FAIL t3_no_accept got %h want 5555aaaa", d);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        bus_read(MEM_READ, 32'h0000_1010, d, rt, lat);
        total_cnt++;
        if (d !== 32'hDEAD_5678) $display("FAIL t4_wrap got %h want dead5678", d);
        else pass_cnt++;
        bus_read(MEM_READ, 32'h8000_0013, d, rt, lat);
        total_cnt++;
        if (d !== 32'hDEAD_5678) $display("FAIL t4_upper_low_bits got %h want dead5678", d);
        else pass_cnt++;
    endtask

    task automatic test_illegal_type();
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        bus_read(2'd3, 32'h10, d, rt, lat);
        total_cnt++;
        if (d !== 32'hDEAD_5678) $display("FAIL illegal_as_read got %h want dead5678", d);
        else pass_cnt++;
        total_cnt++;
        if (rt !== 2'd3) $display("FAIL illegal_type_echo got %0d want 3", rt);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [4];
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        wd[0] = 32'hA0A0_0001;
        wd[1] = 32'hB1B1_0002;
        wd[2] = 32'hC2C2_0003;
        wd[3] = 32'hD3D3_0004;
        for (int i = 0; i < 4; i++) begin
            ifc.req.req_type = MEM_WRITE;
            ifc.req.req_addr = 32'h100 + 32'(4 * i);
            ifc.req.req_data = wd[i];
            ifc.req.req_mask = 4'hF;
            ifc.req_valid    = 1'b1;
            total_cnt++;
            if (ifc.req_ready !== 1'b1) $display("FAIL t5_ready_at_accept %0d got %b want 1", i, ifc.req_ready);
            else pass_cnt++;
`ifndef MEM_SRAM_RESP_WR_ACK_EN
            total_cnt++;
            if (ifc.resp_valid !== 1'b0) $display("FAIL t5_no_resp %0d got %b want 0", i, ifc.resp_valid);
            else pass_cnt++;
            @(posedge clk);
            @(negedge clk);
`else
            @(posedge clk);
            @(negedge clk);
            ifc.req_valid = 1'b0;
            total_cnt++;
            if (ifc.resp_valid !== 1'b1) $display("FAIL t5_ack_valid %0d got %b want 1", i, ifc.resp_valid);
            else pass_cnt++;
            total_cnt++;
            if (ifc.resp.resp_type !== MEM_WRITE) $display("FAIL t5_ack_type %0d got %0d want 1", i, ifc.resp.resp_type);
            else pass_cnt++;
            total_cnt++;
            if (ifc.resp.resp_data !== 32'h0) $display("FAIL t5_ack_data %0d got %h want 0", i, ifc.resp.resp_data);
            else pass_cnt++;
            total_cnt++;
            if (ifc.req_ready !== 1'b0) $display("FAIL t5_ready_low %0d got %b want 0", i, ifc.req_ready);
            else pass_cnt++;
            @(negedge clk);
`endif
        end
        ifc.req_valid = 1'b0;
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL t5_idle_after got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            bus_read(MEM_READ, 32'h100 + 32'(4 * i), d, rt, lat);
            total_cnt++;
            if (d !== wd[i]) $display("FAIL t5_readback %0d got %h want %h", i, d, wd[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  rt;
        int          lat;
        int          bad;
        // Reset while the read is in ACCESS.
        issue(MEM_READ, 32'h104, 32'h0, 4'h0);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL t6_access_valid got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        total_cnt++;
        if (ifc.req_ready !== 1'b0) $display("FAIL t6_ready_in_rst got %b want 0", ifc.req_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ifc.req_ready !== 1'b1) $display("FAIL t6_ready_after got %b want 1", ifc.req_ready);
        else pass_cnt++;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (ifc.resp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        total_cnt++;
        if (bad != 0) $display("FAIL t6_no_stale got %0d cycles valid want 0", bad);
        else pass_cnt++;
        // Reset with an unconsumed response pending: drop must be asynchronous.
        ifc.resp_ready = 1'b0;
        issue(MEM_READ, 32'h108, 32'h0, 4'h0);
        for (int n = 0; n < 20; n++) begin
            if (ifc.resp_valid) break;
            @(negedge clk);
        end
        total_cnt++;
        if (ifc.resp_valid !== 1'b1) $display("FAIL t6_resp_pending got %b want 1", ifc.resp_valid);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL t6_async_drop got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (ifc.resp_valid !== 1'b0) $display("FAIL t6_discarded got %b want 0", ifc.resp_valid);
        else pass_cnt++;
        bus_read(MEM_READ, 32'h104, d, rt, lat);
        total_cnt++;
        if (d !== 32'hB1B1_0002) $display("FAIL t6_retained got %h want b1b10002", d);
        else pass_cnt++;
        bus_read(MEM_READ, 32'h10, d, rt, lat);
        total_cnt++;
        if (d !== 32'hDEAD_5678) $display("FAIL t6_retained_t2 got %h want dead5678", d);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt         = 0;
        total_cnt        = 0;
        rst              = 1'b1;
        ifc.req_valid    = 1'b0;
        ifc.resp_ready   = 1'b1;
        ifc.req          = '0;
        test_reset();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_wrap();
        test_illegal_type();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
